// File: rtl/mult4_seq.sv
// rtl/mult4_seq.sv - 4x4 unsigned shift-add multiplier using an external 4-bit adder
module mult4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] add_x,
  output logic [3:0] add_y,
  output logic       add_cin,
  input  logic [3:0] add_z,
  input  logic       add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] a_reg;
  logic [7:0] p;
  logic [1:0] cnt;
  logic [7:0] p_next;

  // One shift-add step: the adder result (with its carry as the new top bit)
  // replaces the upper half while the multiplier bits shift down.
  assign p_next = {add_cout, add_z, p[3:1]};

  // Adder operands are only live during RUN; held at zero otherwise.
  always_comb begin
    add_x   = 4'b0000;
    add_y   = 4'b0000;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_x = p[7:4];
      add_y = p[0] ? a_reg : 4'b0000;
    end
  end

  // Control FSM with datapath registers and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      a_reg   <= 4'd0;
      p       <= 8'd0;
      product <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            p     <= {4'b0000, b};
            cnt   <= 2'd0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            product <= p_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult4_seq.md
MULT4_SEQ -- requirements
Module: mult4_seq

Interface
Parameters: none.
REQ-001 SHALL have one clock and a synchronous, active-high reset:
- clk    input   1  rising-edge clock; all state changes on it.
- rst    input   1  synchronous active-high reset.
REQ-002 SHALL have these operand and handshake ports:
- start  input   1  request a multiply of a and b; sampled only in IDLE.
- a      input   4  multiplicand, unsigned.
- b      input   4  multiplier, unsigned.
- busy   output  1  high while in RUN.
- done   output  1  one-cycle pulse when product becomes valid.
- product output 8  unsigned a*b, registered, held until the next accepted start.
REQ-003 SHALL have these ports to an external 4-bit ripple adder (X, Y, cin -> Z, cout):
- add_x    output  4  adder operand X.
- add_y    output  4  adder operand Y.
- add_cin  output  1  adder carry-in.
- add_z    input   4  adder sum Z.
- add_cout input   1  adder carry-out.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 SHALL keep internal registers a_reg[3:0], p[7:0] and step count cnt[1:0].
REQ-006 In IDLE with start=1, SHALL on that edge:
- load a_reg=a and p={4'b0000,b};
- clear cnt;
- go to RUN.
REQ-007 In IDLE with start=0, SHALL hold all state.
REQ-008 In RUN, SHALL drive add_x=p[7:4], add_y=(p[0] ? a_reg : 4'b0000) and add_cin=0, combinationally.
REQ-009 Outside RUN, SHALL drive add_x=0, add_y=0 and add_cin=0.
REQ-010 On each RUN edge, SHALL do the shift-add step:
- load p={add_cout, add_z, p[3:1]};
- increment cnt.
REQ-011 SHALL stay in RUN for exactly 4 edges (cnt 0..3).
REQ-012 On the RUN edge with cnt=3, SHALL copy the updated p into product and go to DONE.
REQ-013 SHALL assert done only in DONE, for exactly one cycle.
REQ-014 SHALL go from DONE to IDLE on the next edge, unconditionally.
REQ-015 SHALL assert busy only in RUN.
REQ-016 Latency: start sampled at edge t0 SHALL give done=1 and a valid product in the cycle after edge t4.
- A new start is accepted no earlier than edge t6.
REQ-017 SHALL ignore start in RUN and DONE, with no effect on a_reg, p or product.
REQ-018 SHALL ignore changes on a and b after the accepting edge.
REQ-019 SHALL keep product unchanged from REQ-012 until the edge that completes the next multiply.
REQ-020 Width rules:
- All arithmetic is unsigned.
- The adder carry is kept as p[7] on each step, so no overflow is possible (max 15*15=225).
REQ-021 Boundary cases SHALL need no special-case logic:
- b=0 or a=0 still takes the full 4 RUN steps and yields product=0.
- a=15, b=15 yields 8'hE1.

Reset
REQ-022 When rst=1 at an edge, SHALL set:
- state=IDLE, cnt=0, a_reg=0, p=0;
- product=8'h00, busy=0, done=0.
REQ-023 Reset SHALL take priority over start and over any in-progress RUN or DONE.
- Reset mid-operation discards the partial result; product reads 8'h00 and no done pulse follows.
REQ-024 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-025 The bench SHALL model the adder as Z/cout = X+Y+cin, or instantiate the team's 4-bit adder, and SHALL cover:
- a=3, b=5, start one cycle -> busy high 4 cycles, done pulse in cycle after t4, product=8'h0F, held afterwards.
- a=15, b=15 -> product=8'hE1; add_cout=1 observed on at least one RUN step.
- a=9, b=0, then a=0, b=9 -> product=8'h00 both times; each still 4 busy cycles.
- a=2, b=3 accepted; start pulsed with a=7, b=7 during RUN and DONE -> product=8'h06; no second done.
- a=6, b=7 started; rst=1 on 2nd RUN cycle -> next cycle busy=0, done=0, product=8'h00; then a=6, b=7 -> 8'h2A.
- Back-to-back: start held high -> done every 6 cycles; products match a*b sampled at each accepting edge.
